encoder_8b10b_multi: RTL and testbench

- Parametrised successor to the single-byte 8b/10b transmit encoder.
- Encodes BYTES bytes per INTERCLK cycle, chaining running disparity (RD) across lanes within a word and across words.
- Adds a valid/ready handshake with backpressure, per-lane illegal K-code flagging, and compliance-mode forced-negative disparity.
- Sits between the transmit data path and the serializer.

---
 rtl/encoder_8b10b_multi.sv | 175 +++++++++++++++++
 tb/tb_encoder_8b10b_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8b10b_multi.sv
// encoder_8b10b_multi
// Multi-lane 8b/10b transmit encoder (IEEE 802.3 Clause 36 code tables).
// Encodes BYTES byte lanes per clock with running disparity chained lane 0 ->
// lane BYTES-1 inside a word and carried across words. A single output
// register stage with valid/ready handshake gives 1-cycle latency and full
// throughput. Illegal K codes are flagged per lane and replaced by K28.5.
//
// Ports:
//   INTERCLK  clock
//   Reset     asynchronous reset, active low
//   iData     input bytes, lane i = iData[8i+7:8i] = {HGF,EDCBA}
//   TXDATAK   per-lane K flag
//   TXCOMP    compliance: lane 0 of this word starts from negative RD
//   iValid    input word valid
//   iReady    block can accept a word this cycle
//   oData     encoded lanes, lane i = oData[10i+9:10i] = abcdei fghj (a = MSB)
//   oValid    oData valid
//   oReady    downstream accepts oData
//   oKErr     per-lane illegal K flag, aligned with oData
//   oRD       registered running disparity (0 = negative, 1 = positive)
module encoder_8b10b_multi #(
  parameter int BYTES = 2
) (
  input  logic                INTERCLK,
  input  logic                Reset,
  input  logic [8*BYTES-1:0]  iData,
  input  logic [BYTES-1:0]    TXDATAK,
  input  logic                TXCOMP,
  input  logic                iValid,
  output logic                iReady,
  output logic [10*BYTES-1:0] oData,
  output logic                oValid,
  input  logic                oReady,
  output logic [BYTES-1:0]    oKErr,
  output logic                oRD
);

  logic [10*BYTES-1:0] r_data;
  logic [BYTES-1:0]    r_kerr;
  logic                r_valid;
  logic                r_rd;

  logic [10*BYTES-1:0] w_data;
  logic [BYTES-1:0]    w_kerr;
  logic                w_rd_next;
  logic                w_accept;

  // 5b/6b table, RD-negative column (abcdei).
  function automatic logic [5:0] f_6b(input logic [4:0] x);
    case (x)
      5'd0:  f_6b = 6'b100111;  5'd1:  f_6b = 6'b011101;
      5'd2:  f_6b = 6'b101101;  5'd3:  f_6b = 6'b110001;
      5'd4:  f_6b = 6'b110101;  5'd5:  f_6b = 6'b101001;
      5'd6:  f_6b = 6'b011001;  5'd7:  f_6b = 6'b111000;
      5'd8:  f_6b = 6'b111001;  5'd9:  f_6b = 6'b100101;
      5'd10: f_6b = 6'b010101;  5'd11: f_6b = 6'b110100;
      5'd12: f_6b = 6'b001101;  5'd13: f_6b = 6'b101100;
      5'd14: f_6b = 6'b011100;  5'd15: f_6b = 6'b010111;
      5'd16: f_6b = 6'b011011;  5'd17: f_6b = 6'b100011;
      5'd18: f_6b = 6'b010011;  5'd19: f_6b = 6'b110010;
      5'd20: f_6b = 6'b001011;  5'd21: f_6b = 6'b101010;
      5'd22: f_6b = 6'b011010;  5'd23: f_6b = 6'b111010;
      5'd24: f_6b = 6'b110011;  5'd25: f_6b = 6'b100110;
      5'd26: f_6b = 6'b010110;  5'd27: f_6b = 6'b110110;
      5'd28: f_6b = 6'b001110;  5'd29: f_6b = 6'b101110;
      5'd30: f_6b = 6'b011110;  5'd31: f_6b = 6'b101011;
      default: f_6b = 6'b101011;
    endcase
  endfunction

  // 3b/4b data table, RD-negative column (fghj), primary D.x.7.
  function automatic logic [3:0] f_4b_d(input logic [2:0] y);
    case (y)
      3'd0: f_4b_d = 4'b1011;  3'd1: f_4b_d = 4'b1001;
      3'd2: f_4b_d = 4'b0101;  3'd3: f_4b_d = 4'b1100;
      3'd4: f_4b_d = 4'b1101;  3'd5: f_4b_d = 4'b1010;
      3'd6: f_4b_d = 4'b0110;  3'd7: f_4b_d = 4'b1110;
      default: f_4b_d = 4'b1110;
    endcase
  endfunction

  // 3b/4b control table, RD-negative column; always complemented at RD+.
  function automatic logic [3:0] f_4b_k(input logic [2:0] y);
    case (y)
      3'd0: f_4b_k = 4'b1011;  3'd1: f_4b_k = 4'b0110;
      3'd2: f_4b_k = 4'b1010;  3'd3: f_4b_k = 4'b1100;
      3'd4: f_4b_k = 4'b1101;  3'd5: f_4b_k = 4'b0101;
      3'd6: f_4b_k = 4'b1001;  3'd7: f_4b_k = 4'b0111;
      default: f_4b_k = 4'b0111;
    endcase
  endfunction

  // Legal K characters: K28.0-7, K23.7, K27.7, K29.7, K30.7.
  function automatic logic f_k_legal(input logic [7:0] b);
    f_k_legal = (b[4:0] == 5'd28) ||
                ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                      (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

  // Encode one lane; returns {rd_out, abcdei, fghj}.
  function automatic logic [10:0] f_enc_lane(input logic [7:0] b, input logic k,
                                             input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unb6;
    logic       unb4;
    logic       rd_mid;
    logic       alt7;
    x      = b[4:0];
    y      = b[7:5];
    c6     = (k && (x == 5'd28)) ? 6'b001111 : f_6b(x);
    unb6   = ($countones(c6) != 32'sd3);
    // D7 is balanced but still has distinct RD- / RD+ forms.
    c6     = (rd && (unb6 || (!k && (x == 5'd7)))) ? ~c6 : c6;
    rd_mid = rd ^ unb6;
    // A7 avoids a run of five equal bits across the sub-block boundary.
    alt7   = !k && (y == 3'd7) &&
             (rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                     : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)));
    c4     = k ? f_4b_k(y) : (alt7 ? 4'b0111 : f_4b_d(y));
    unb4   = ($countones(c4) != 32'sd2);
    c4     = (rd_mid && (k || unb4 || (y == 3'd3))) ? ~c4 : c4;
    f_enc_lane = {rd_mid ^ unb4, c6, c4};
  endfunction

  assign iReady   = !r_valid || oReady;
  assign w_accept = iValid && iReady;

  // Lane encoders with running disparity rippling from lane 0 upward.
  always_comb begin
    logic        v_rd;
    logic        v_err;
    logic [7:0]  v_byte;
    logic [10:0] v_enc;
    w_data = '0;
    w_kerr = '0;
    v_rd   = TXCOMP ? 1'b0 : r_rd;
    for (int i = 0; i < BYTES; i++) begin
      v_err     = TXDATAK[i] && !f_k_legal(iData[8*i +: 8]);
      v_byte    = v_err ? 8'hBC : iData[8*i +: 8];
      v_enc     = f_enc_lane(v_byte, TXDATAK[i], v_rd);
      w_kerr[i] = v_err;
      w_data[10*i +: 10] = v_enc[9:0];
      v_rd      = v_enc[10];
    end
    w_rd_next = v_rd;
  end

  // Output register and running disparity; RD moves only on accept.
  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      r_data  <= '0;
      r_kerr  <= '0;
      r_valid <= 1'b0;
      r_rd    <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_data;
      r_kerr  <= w_kerr;
      r_valid <= 1'b1;
      r_rd    <= w_rd_next;
    end else if (oReady) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign oData  = r_data;
  assign oKErr  = r_kerr;
  assign oValid = r_valid;
  assign oRD    = r_rd;

endmodule

// File: tb/tb_encoder_8b10b_multi.sv
// Testbench for encoder_8b10b_multi (BYTES = 2). Scoreboard of expected
// encoded words built from an independent disparity-driven model of the
// Clause 36 tables, plus directly known code values for key characters.
module tb_encoder_8b10b_multi;

  localparam int BYTES = 2;

  logic                INTERCLK;
  logic                Reset;
  logic [8*BYTES-1:0]  iData;
  logic [BYTES-1:0]    TXDATAK;
  logic                TXCOMP;
  logic                iValid;
  logic                iReady;
  logic [10*BYTES-1:0] oData;
  logic                oValid;
  logic                oReady;
  logic [BYTES-1:0]    oKErr;
  logic                oRD;

  encoder_8b10b_multi #(.BYTES(BYTES)) dut (
    .INTERCLK(INTERCLK), .Reset(Reset), .iData(iData), .TXDATAK(TXDATAK),
    .TXCOMP(TXCOMP), .iValid(iValid), .iReady(iReady), .oData(oData),
    .oValid(oValid), .oReady(oReady), .oKErr(oKErr), .oRD(oRD)
  );

  typedef struct packed {
    logic [19:0] data;
    logic [1:0]  kerr;
    logic        rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic m_rd     = 1'b0;
  logic m_valid  = 1'b0;

  logic [5:0] t6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001,
                          6'b110101, 6'b101001, 6'b011001, 6'b111000,
                          6'b111001, 6'b100101, 6'b010101, 6'b110100,
                          6'b001101, 6'b101100, 6'b011100, 6'b010111,
                          6'b011011, 6'b100011, 6'b010011, 6'b110010,
                          6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110,
                          6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] t4d [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                          4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] t4k [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                          4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [7:0] k_list [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                              8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  initial begin
    INTERCLK = 1'b0;
    forever #5 INTERCLK = ~INTERCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic k_ok(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) if (k_list[i] == b) ok = 1'b1;
    return ok;
  endfunction

  // Returns {kerr, rd_out, code10}; RD follows the disparity of each chosen sub-block.
  function automatic logic [11:0] model_lane(input logic [7:0] b, input logic k,
                                             input logic rd);
    logic       kerr, rdm, rdo, alt;
    logic [7:0] bb;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    kerr = k && !k_ok(b);
    bb   = kerr ? 8'hBC : b;
    x    = bb[4:0];
    y    = bb[7:5];
    c6   = (k && x == 5'd28) ? 6'b001111 : t6[x];
    if (rd && ($countones(c6) != 3 || (!k && x == 5'd7))) c6 = ~c6;
    rdm  = ($countones(c6) > 3) ? 1'b1 : (($countones(c6) < 3) ? 1'b0 : rd);
    if (k) begin
      c4 = rdm ? ~t4k[y] : t4k[y];
    end else begin
      alt = (y == 3'd7) && (rdm ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                                : (x == 5'd17 || x == 5'd18 || x == 5'd20));
      c4  = alt ? 4'b0111 : t4d[y];
      if (rdm && ($countones(c4) != 2 || y == 3'd3)) c4 = ~c4;
    end
    rdo = ($countones(c4) > 2) ? 1'b1 : (($countones(c4) < 2) ? 1'b0 : rdm);
    return {kerr, rdo, c6, c4};
  endfunction

  function automatic exp_t model_word(input logic [15:0] d, input logic [1:0] k,
                                      input logic comp, input logic rd);
    exp_t        e;
    logic [11:0] l0, l1;
    l0     = model_lane(d[7:0], k[0], comp ? 1'b0 : rd);
    l1     = model_lane(d[15:8], k[1], l0[10]);
    e.data = {l1[9:0], l0[9:0]};
    e.kerr = {l1[11], l0[11]};
    e.rd   = l1[10];
    return e;
  endfunction

  // One clock cycle: apply inputs after the falling edge, check, then advance.
  task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic comp,
                       input logic v, input logic r);
    exp_t e;
    logic acc;
    iData = d; TXDATAK = k; TXCOMP = comp; iValid = v; oReady = r;
    #1;
    check_val("ovalid", 32'(oValid), 32'(m_valid));
    check_val("iready", 32'(iReady), 32'(!m_valid || r));
    if (m_valid && r) begin
      check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("odata", 32'(oData), 32'(e.data));
        check_val("okerr", 32'(oKErr), 32'(e.kerr));
        check_val("ord", 32'(oRD), 32'(e.rd));
      end
    end
    acc = v && (!m_valid || r);
    if (acc) begin
      e = model_word(d, k, comp, m_rd);
      m_rd = e.rd;
      sb.push_back(e);
    end
    m_valid = acc ? 1'b1 : (r ? 1'b0 : m_valid);
    @(negedge INTERCLK);
  endtask

  int hn [6] = '{32'h34E, 32'h2CE, 32'h1CE, 32'h237, 32'h137, 32'h0B7};
  int hp [6] = '{32'h348, 32'h2C8, 32'h1C8, 32'h231, 32'h131, 32'h0B1};
  int xs [6] = '{11, 13, 14, 17, 18, 20};

  initial begin
    logic [19:0] od;
    logic [7:0]  b0, b1;
    Reset = 1'b0;
    iData = '0; TXDATAK = '0; TXCOMP = 1'b0; iValid = 1'b0; oReady = 1'b0;
    // Reset held with random inputs.
    for (int c = 0; c < 4; c++) begin
      iData = 16'($urandom); TXDATAK = 2'($urandom); TXCOMP = 1'($urandom);
      iValid = 1'($urandom); oReady = 1'($urandom);
      @(negedge INTERCLK);
      check_val("rst_ovalid", 32'(oValid), 32'd0);
      check_val("rst_odata", 32'(oData), 32'd0);
      check_val("rst_okerr", 32'(oKErr), 32'd0);
      check_val("rst_ord", 32'(oRD), 32'd0);
    end
    iValid = 1'b0;
    Reset = 1'b1;
    #1;
    check_val("rst_iready", 32'(iReady), 32'd1);
    @(negedge INTERCLK);

    // K28.5 pair from RD-.
    drive(16'hBCBC, 2'b11, 1'b0, 1'b1, 1'b1);
    check_val("k285_pair", 32'(oData), {12'h0, 10'h305, 10'h0FA});
    check_val("k285_rd", 32'(oRD), 32'd0);
    drive(16'hB5B5, 2'b00, 1'b0, 1'b1, 1'b1);
    check_val("d21_5", 32'(oData), {12'h0, 10'h2AA, 10'h2AA});
    check_val("d21_5_rd", 32'(oRD), 32'd0);
    drive(16'h0000, 2'b00, 1'b0, 1'b1, 1'b1);
    check_val("d0_0", 32'(oData), {12'h0, 10'h274, 10'h274});
    check_val("d0_0_rd", 32'(oRD), 32'd0);

    // Backpressure: word A held for 5 cycles while B waits.
    drive(16'h1234, 2'b00, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(16'h5678, 2'b00, 1'b0, 1'b1, 1'b0);
      check_val("bp_hold", 32'(oData), 32'(sb[0].data));
      check_val("bp_rd", 32'(oRD), 32'(sb[0].rd));
    end
    drive(16'h5678, 2'b00, 1'b0, 1'b1, 1'b1);
    drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);

    // Compliance: reach RD+, then force lane 0 negative.
    drive(16'hB5BC, 2'b01, 1'b1, 1'b1, 1'b1);
    check_val("comp_pre_rd", 32'(oRD), 32'd1);
    drive(16'hB5BC, 2'b01, 1'b1, 1'b1, 1'b1);
    od = oData;
    check_val("comp_lane0", 32'(od[9:0]), 32'h0FA);

    // Illegal K on lane 0 becomes K28.5; lane 1 D0.0 sees RD+.
    drive(16'h0000, 2'b01, 1'b1, 1'b1, 1'b1);
    check_val("kerr_flag", 32'(oKErr), 32'd1);
    check_val("kerr_data", 32'(oData), {12'h0, 10'h18B, 10'h0FA});
    check_val("kerr_rd", 32'(oRD), 32'd1);

    // D.x.7 sweep on lane 1 at both running disparities.
    for (int i = 0; i < 6; i++) begin
      b1 = {3'b111, 5'(xs[i])};
      drive({b1, 8'hB5}, 2'b00, 1'b1, 1'b1, 1'b1);
      od = oData;
      check_val("a7_rdneg", 32'(od[19:10]), 32'(hn[i]));
      drive({b1, 8'hBC}, 2'b01, 1'b1, 1'b1, 1'b1);
      od = oData;
      check_val("a7_rdpos", 32'(od[19:10]), 32'(hp[i]));
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      b0 = ($urandom_range(0, 2) == 0) ? k_list[$urandom_range(0, 11)] : 8'($urandom);
      b1 = ($urandom_range(0, 2) == 0) ? k_list[$urandom_range(0, 11)] : 8'($urandom);
      drive({b1, b0}, 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    // Reset asserted with a word in flight discards it.
    drive(16'h4321, 2'b00, 1'b0, 1'b1, 1'b1);
    iValid = 1'b0; oReady = 1'b0;
    #1;
    Reset = 1'b0;
    #1;
    check_val("mid_rst_ovalid", 32'(oValid), 32'd0);
    check_val("mid_rst_odata", 32'(oData), 32'd0);
    check_val("mid_rst_ord", 32'(oRD), 32'd0);
    sb.delete();
    m_valid = 1'b0;
    m_rd = 1'b0;
    @(negedge INTERCLK);
    Reset = 1'b1;
    @(negedge INTERCLK);
    drive(16'hBCBC, 2'b11, 1'b0, 1'b1, 1'b1);
    check_val("post_rst_k285", 32'(oData), {12'h0, 10'h305, 10'h0FA});

    // Drain.
    for (int c = 0; c < 3; c++) drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b1);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
